// File: rtl/mac_pkg.sv
// Shared MAC datatypes and the converter scheduler state encoding.
package mac_pkg;

    localparam int MAC_W_DATATYPE = 3;

    localparam logic [MAC_W_DATATYPE-1:0] MAC_DATATYPE_I9   = 3'd0;
    localparam logic [MAC_W_DATATYPE-1:0] MAC_DATATYPE_I4   = 3'd1;
    localparam logic [MAC_W_DATATYPE-1:0] MAC_DATATYPE_FP16 = 3'd2;
    localparam logic [MAC_W_DATATYPE-1:0] MAC_DATATYPE_BF16 = 3'd3;
    localparam logic [MAC_W_DATATYPE-1:0] MAC_DATATYPE_FP8  = 3'd4;

    typedef enum logic [0:0] {
        MAC_CVT_RUN   = 1'b0,
        MAC_CVT_DRAIN = 1'b1
    } mac_cvt_state_e;

endpackage

// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter: one-hot grant in the same cycle, search starts at the
// pointer, which moves past the granted requester.
module mac_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt
);

    localparam int PW  = (N > 1) ? $clog2(N) : 1;
    localparam int PW1 = PW + 1;

    logic [PW-1:0] ptr_r;
    logic [PW-1:0] ptr_nxt_s;
    logic [N-1:0]  gnt_s;
    logic [PW:0]   idx_s;
    logic          found_s;

    // First requester at or after the pointer, wrapping modulo N
    always_comb begin
        gnt_s     = '0;
        found_s   = 1'b0;
        ptr_nxt_s = ptr_r;
        idx_s     = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = {1'b0, ptr_r} + PW1'(i);
            if (idx_s >= PW1'(N)) begin
                idx_s = idx_s - PW1'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && i_en && i_req[idx_s[PW-1:0]]) begin
                found_s                = 1'b1;
                gnt_s[idx_s[PW-1:0]]   = 1'b1;
                ptr_nxt_s              = (idx_s[PW-1:0] == PW'(N - 1)) ? '0
                                                                       : idx_s[PW-1:0] + PW'(1);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer register; unchanged when nothing is granted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign o_gnt = gnt_s;

endmodule

// File: rtl/mac_fp32_cvt_sched.sv
// Shares one FP32 converter among N_REQ MAC lanes with valid/tag tracking and
// drain-before-reconfigure. Optional counters: define MAC_CVT_SCHED_PERF_EN.
module mac_fp32_cvt_sched
    import mac_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W_I_EXP = 6,
    parameter int W_I_INT = 34,
    parameter int STAGE   = 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_cfg_valid,
    input  logic [MAC_W_DATATYPE-1:0]           i_cfg_ifm_datatype,
    input  logic [MAC_W_DATATYPE-1:0]           i_cfg_wfm_datatype,
    output logic                                o_cfg_ready,
    input  logic [N_REQ-1:0]                    i_req_valid,
    input  logic [N_REQ-1:0][W_I_EXP-1:0]       i_req_exp,
    input  logic [N_REQ-1:0][W_I_INT-1:0]       i_req_intdata,
    output logic [N_REQ-1:0]                    o_req_ready,
    output logic [MAC_W_DATATYPE-1:0]           o_cvt_ifm_datatype,
    output logic [MAC_W_DATATYPE-1:0]           o_cvt_wfm_datatype,
    output logic [W_I_EXP-1:0]                  o_cvt_exp,
    output logic [W_I_INT-1:0]                  o_cvt_intdata,
    output logic [STAGE-1:0]                    o_cvt_pipe_en,
    input  logic [31:0]                         i_cvt_data,
    output logic                                o_valid,
    output logic [31:0]                         o_data,
    output logic [$clog2(N_REQ)-1:0]            o_id,
    input  logic                                i_ready,
    output logic                                o_busy
`ifdef MAC_CVT_SCHED_PERF_EN
    ,
    output logic [31:0]                         o_perf_conv,
    output logic [31:0]                         o_perf_stall
`endif
);

    localparam int ID_W = $clog2(N_REQ);

    logic [STAGE-1:0]           v_r;
    logic [STAGE-1:0][ID_W-1:0] id_r;
    logic [STAGE-1:0]           adv_s;
    logic [STAGE-1:0]           pipe_en_s;
    mac_cvt_state_e             state_r;
    mac_cvt_state_e             state_nxt_s;
    logic [MAC_W_DATATYPE-1:0]  ifm_r;
    logic [MAC_W_DATATYPE-1:0]  wfm_r;
    logic [N_REQ-1:0]           gnt_s;
    logic                       gnt_any_s;
    logic                       arb_en_s;
    logic                       cfg_acc_s;
    logic [ID_W-1:0]            gnt_id_s;
    logic [W_I_EXP-1:0]         exp_mux_s;
    logic [W_I_INT-1:0]         int_mux_s;

    // Grants are withheld while reset is asserted so o_req_ready drops at once
    assign arb_en_s  = (state_r == MAC_CVT_RUN) & ~i_cfg_valid & adv_s[0] & ~i_rst;
    assign gnt_any_s = |gnt_s;

    mac_rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (i_req_valid),
        .i_en  (arb_en_s),
        .o_gnt (gnt_s)
    );

    // Backpressure chain: a stage may advance if empty or its successor advances
    always_comb begin
        adv_s            = '0;
        adv_s[STAGE-1]   = ~v_r[STAGE-1] | i_ready;
        for (int k = STAGE - 2; k >= 0; k--) begin
            adv_s[k] = ~v_r[k] | adv_s[k+1];
        end
    end

    // Stage enables handed to the converter
    always_comb begin
        pipe_en_s    = '0;
        pipe_en_s[0] = gnt_any_s & adv_s[0];
        for (int k = 1; k < STAGE; k++) begin
            pipe_en_s[k] = v_r[k-1] & adv_s[k];
        end
    end

    // One-hot grant to lane index and AND-OR operand mux
    always_comb begin
        gnt_id_s  = '0;
        exp_mux_s = '0;
        int_mux_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt_id_s  = gnt_id_s  | (ID_W'(i) & {ID_W{gnt_s[i]}});
            exp_mux_s = exp_mux_s | (i_req_exp[i] & {W_I_EXP{gnt_s[i]}});
            int_mux_s = int_mux_s | (i_req_intdata[i] & {W_I_INT{gnt_s[i]}});
        end
    end

    // RUN/DRAIN next state; config is taken only once every stage is empty
    always_comb begin
        state_nxt_s = state_r;
        cfg_acc_s   = 1'b0;
        case (state_r)
            MAC_CVT_RUN: begin
                if (i_cfg_valid) begin
                    state_nxt_s = MAC_CVT_DRAIN;
                end else begin
                    state_nxt_s = MAC_CVT_RUN;
                end
            end
            MAC_CVT_DRAIN: begin
                if (v_r == '0) begin
                    cfg_acc_s   = 1'b1;
                    state_nxt_s = MAC_CVT_RUN;
                end else begin
                    state_nxt_s = MAC_CVT_DRAIN;
                end
            end
            default: begin
                state_nxt_s = MAC_CVT_RUN;
            end
        endcase
    end

    // FSM state and latched datatype configuration
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= MAC_CVT_RUN;
            ifm_r   <= MAC_DATATYPE_I9;
            wfm_r   <= MAC_DATATYPE_I9;
        end else begin
            state_r <= state_nxt_s;
            if (cfg_acc_s) begin
                ifm_r <= i_cfg_ifm_datatype;
                wfm_r <= i_cfg_wfm_datatype;
            end
        end
    end

    // Valid bits and lane tags shadowing the converter pipeline
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v_r  <= '0;
            id_r <= '0;
        end else begin
            if (adv_s[0]) begin
                v_r[0]  <= gnt_any_s;
                id_r[0] <= gnt_id_s;
            end
            for (int k = 1; k < STAGE; k++) begin
                if (adv_s[k]) begin
                    v_r[k]  <= v_r[k-1];
                    id_r[k] <= id_r[k-1];
                end
            end
        end
    end

`ifdef MAC_CVT_SCHED_PERF_EN
    logic [31:0] perf_conv_r;
    logic [31:0] perf_stall_r;

    // Completed conversions and lost-arbitration cycles, cleared by a new config
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            perf_conv_r  <= 32'd0;
            perf_stall_r <= 32'd0;
        end else if (cfg_acc_s) begin
            perf_conv_r  <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (v_r[STAGE-1] && i_ready) begin
                perf_conv_r <= perf_conv_r + 32'd1;
            end
            if ((|i_req_valid) && !gnt_any_s) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign o_perf_conv  = perf_conv_r;
    assign o_perf_stall = perf_stall_r;
`endif

    assign o_cfg_ready        = cfg_acc_s;
    assign o_req_ready        = gnt_s;
    assign o_cvt_ifm_datatype = ifm_r;
    assign o_cvt_wfm_datatype = wfm_r;
    assign o_cvt_exp          = exp_mux_s;
    assign o_cvt_intdata      = int_mux_s;
    assign o_cvt_pipe_en      = pipe_en_s;
    assign o_valid            = v_r[STAGE-1];
    assign o_id               = id_r[STAGE-1];
    assign o_data             = i_cvt_data;
    assign o_busy             = (|v_r) | (state_r == MAC_CVT_DRAIN);

endmodule

// File: tb/tb_mac_fp32_cvt_sched.sv
// Bench for mac_fp32_cvt_sched: a two-stage integer-to-FP32 converter stand-in,
// a queue-based reference model, a directed vector table and random traffic.
module tb_mac_fp32_cvt_sched;
    import mac_pkg::*;

    localparam int N  = 4;
    localparam int EW = 6;
    localparam int IW = 34;
    localparam int S  = 2;

    logic                       i_clk = 1'b0;
    logic                       i_rst;
    logic                       i_cfg_valid;
    logic [MAC_W_DATATYPE-1:0]  i_cfg_ifm_datatype;
    logic [MAC_W_DATATYPE-1:0]  i_cfg_wfm_datatype;
    logic                       o_cfg_ready;
    logic [N-1:0]               i_req_valid;
    logic [N-1:0][EW-1:0]       i_req_exp;
    logic [N-1:0][IW-1:0]       i_req_intdata;
    logic [N-1:0]               o_req_ready;
    logic [MAC_W_DATATYPE-1:0]  o_cvt_ifm_datatype;
    logic [MAC_W_DATATYPE-1:0]  o_cvt_wfm_datatype;
    logic [EW-1:0]              o_cvt_exp;
    logic [IW-1:0]              o_cvt_intdata;
    logic [S-1:0]               o_cvt_pipe_en;
    logic [31:0]                i_cvt_data;
    logic                       o_valid;
    logic [31:0]                o_data;
    logic [1:0]                 o_id;
    logic                       i_ready;
    logic                       o_busy;
`ifdef MAC_CVT_SCHED_PERF_EN
    logic [31:0]                o_perf_conv;
    logic [31:0]                o_perf_stall;
`endif

    mac_fp32_cvt_sched #(
        .N_REQ (N), .W_I_EXP (EW), .W_I_INT (IW), .STAGE (S)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_cfg_valid        (i_cfg_valid),
        .i_cfg_ifm_datatype (i_cfg_ifm_datatype),
        .i_cfg_wfm_datatype (i_cfg_wfm_datatype),
        .o_cfg_ready        (o_cfg_ready),
        .i_req_valid        (i_req_valid),
        .i_req_exp          (i_req_exp),
        .i_req_intdata      (i_req_intdata),
        .o_req_ready        (o_req_ready),
        .o_cvt_ifm_datatype (o_cvt_ifm_datatype),
        .o_cvt_wfm_datatype (o_cvt_wfm_datatype),
        .o_cvt_exp          (o_cvt_exp),
        .o_cvt_intdata      (o_cvt_intdata),
        .o_cvt_pipe_en      (o_cvt_pipe_en),
        .i_cvt_data         (i_cvt_data),
        .o_valid            (o_valid),
        .o_data             (o_data),
        .o_id               (o_id),
        .i_ready            (i_ready),
        .o_busy             (o_busy)
`ifdef MAC_CVT_SCHED_PERF_EN
        ,
        .o_perf_conv        (o_perf_conv),
        .o_perf_stall       (o_perf_stall)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Signed integer * 2^(exp - bias) to FP32, mantissa truncated
    function automatic logic [31:0] cvt(input logic [MAC_W_DATATYPE-1:0] dt,
                                        input logic [EW-1:0] e, input logic [IW-1:0] d);
        logic [IW-1:0] mag;
        logic [22:0]   man;
        int            msb;
        int            ex;
        if (d == '0) return 32'h0;
        mag = d[IW-1] ? (~d + 34'd1) : d;
        msb = 0;
        for (int i = 0; i < IW; i++) if (mag[i]) msb = i;
        if (msb <= 23) man = 23'(mag << (23 - msb));
        else           man = 23'(mag >> (msb - 23));
        ex = 127 + msb + int'(e) - ((dt == MAC_DATATYPE_FP16) ? 15 : 0);
        return {d[IW-1], 8'(ex), man};
    endfunction

    // Converter stand-in: two stages gated by the scheduler's stage enables
    logic [31:0] stub0, stub1;
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stub0 <= 32'h0;
            stub1 <= 32'h0;
        end else begin
            if (o_cvt_pipe_en[0]) stub0 <= cvt(o_cvt_ifm_datatype, o_cvt_exp, o_cvt_intdata);
            if (o_cvt_pipe_en[1]) stub1 <= stub0;
        end
    end
    assign i_cvt_data = stub1;

    int nerr = 0;
    int nchk = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: in-flight items with pipeline positions
    typedef struct { int lane; logic [31:0] data; int pos; } item_t;
    item_t m_q[$];
    item_t m_nq[$];
    int    m_ptr;
    bit    m_drain;
    logic [MAC_W_DATATYPE-1:0] m_ifm, m_wfm;
    int    e_gnt;
    bit    e_cfg;

    logic [N-1:0] s_gnt;
    logic [S-1:0] s_pe;
    logic         s_valid, s_cfg_rdy;

    function automatic void model_reset();
        m_q.delete();
        m_ptr   = 0;
        m_drain = 1'b0;
        m_ifm   = MAC_DATATYPE_I9;
        m_wfm   = MAC_DATATYPE_I9;
    endfunction

    function automatic void model_check();
        bit           fire, room, ev;
        logic [N-1:0] eg;
        logic [S-1:0] epe;
        int           lim;
        fire  = (m_q.size() > 0) && (m_q[0].pos == S - 1) && i_ready;
        room  = (m_q.size() < S) || fire;
        e_gnt = -1;
        if (!m_drain && !i_cfg_valid && room) begin
            for (int i = 0; i < N; i++) begin
                int l;
                l = (m_ptr + i) % N;
                if (i_req_valid[l] && e_gnt < 0) e_gnt = l;
            end
        end
        e_cfg = m_drain && (m_q.size() == 0);
        eg    = (e_gnt >= 0) ? 4'(4'b1 << e_gnt) : 4'b0;
        epe   = '0;
        m_nq.delete();
        lim = S - 1;
        for (int j = 0; j < m_q.size(); j++) begin
            item_t it;
            it = m_q[j];
            if (j == 0 && fire) continue;
            if (it.pos < lim) begin
                epe[it.pos + 1] = 1'b1;
                it.pos++;
            end
            lim = it.pos - 1;
            m_nq.push_back(it);
        end
        if (e_gnt >= 0) begin
            item_t ni;
            epe[0]  = 1'b1;
            ni.lane = e_gnt;
            ni.data = cvt(m_ifm, i_req_exp[e_gnt], i_req_intdata[e_gnt]);
            ni.pos  = 0;
            m_nq.push_back(ni);
            chk("cvt_exp", o_cvt_exp, i_req_exp[e_gnt]);
            chk("cvt_intdata", o_cvt_intdata, i_req_intdata[e_gnt]);
        end
        ev = (m_q.size() > 0) && (m_q[0].pos == S - 1);
        chk("req_ready", o_req_ready, eg);
        chk("valid", o_valid, ev);
        if (ev) begin
            chk("id", o_id, m_q[0].lane);
            chk("data", o_data, m_q[0].data);
        end
        chk("cfg_ready", o_cfg_ready, e_cfg);
        chk("busy", o_busy, (m_q.size() > 0) || m_drain);
        chk("pipe_en", o_cvt_pipe_en, epe);
        chk("ifm_dt", o_cvt_ifm_datatype, m_ifm);
        chk("wfm_dt", o_cvt_wfm_datatype, m_wfm);
    endfunction

    function automatic void model_advance();
        m_q = m_nq;
        if (e_gnt >= 0) m_ptr = (e_gnt + 1) % N;
        if (e_cfg) begin
            m_ifm   = i_cfg_ifm_datatype;
            m_wfm   = i_cfg_wfm_datatype;
            m_drain = 1'b0;
        end else if (!m_drain && i_cfg_valid) begin
            m_drain = 1'b1;
        end
    endfunction

    typedef struct {
        logic [N-1:0] req; logic rdy; logic cfgv;
        logic [N-1:0] egnt; logic ecfg; logic ev; logic [1:0] eid; logic [31:0] edata;
    } vec_t;
    vec_t tbl[17];

    task automatic tick(input bit use_row, input vec_t r);
        @(negedge i_clk);
        s_gnt     = o_req_ready;
        s_pe      = o_cvt_pipe_en;
        s_valid   = o_valid;
        s_cfg_rdy = o_cfg_ready;
        if (use_row) begin
            chk("tbl_gnt", o_req_ready, r.egnt);
            chk("tbl_cfg_ready", o_cfg_ready, r.ecfg);
            chk("tbl_valid", o_valid, r.ev);
            if (r.ev) begin
                chk("tbl_id", o_id, r.eid);
                chk("tbl_data", o_data, r.edata);
            end
        end
        model_check();
        @(posedge i_clk);
        model_advance();
        #1;
    endtask

    vec_t nullrow;
    bit   cfg_pending;
    bit   saw;

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, 2'd0, 32'h40A0_0000};
        tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, 2'd1, 32'h40C0_0000};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd2, 32'h40E0_0000};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 32'h4100_0000};
        tbl[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 32'h40A0_0000};
        tbl[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[8]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 32'h40A0_0000};
        tbl[11] = '{4'b0100, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[12] = '{4'b0100, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 32'h0};
        tbl[13] = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 32'h40E0_0000};
        tbl[16] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0};
        nullrow = '{4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 2'd0, 32'h0};

        i_rst = 1'b1;
        i_cfg_valid = 1'b0;
        i_cfg_ifm_datatype = MAC_DATATYPE_I9;
        i_cfg_wfm_datatype = MAC_DATATYPE_I9;
        i_req_valid = 4'b1111;
        i_ready = 1'b1;
        for (int l = 0; l < N; l++) begin
            i_req_exp[l]     = 6'd0;
            i_req_intdata[l] = 34'(5 + l);
        end
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_req_ready", o_req_ready, 4'b0000);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_pipe_en", o_cvt_pipe_en, 2'b00);
        chk("rst_cfg_ready", o_cfg_ready, 1'b0);
        chk("rst_ifm_dt", o_cvt_ifm_datatype, MAC_DATATYPE_I9);
        i_rst = 1'b0;
        model_reset();

        // Directed table: round robin, single lane latency, cfg beats request
        for (int i = 0; i < 17; i++) begin
            i_req_valid = tbl[i].req;
            i_ready     = tbl[i].rdy;
            i_cfg_valid = tbl[i].cfgv;
            tick(1'b1, tbl[i]);
        end

        // Output stall with all lanes requesting
        i_req_valid = 4'b1111;
        i_ready     = 1'b1;
        repeat (3) tick(1'b0, nullrow);
        i_ready = 1'b0;
        repeat (5) begin
            tick(1'b0, nullrow);
            chk("stall_pipe_en", s_pe, 2'b00);
            chk("stall_gnt", s_gnt, 4'b0000);
            chk("stall_valid", s_valid, 1'b1);
        end
        i_ready     = 1'b1;
        i_req_valid = 4'b0000;
        repeat (4) tick(1'b0, nullrow);

        // Reconfigure to FP16 with two results in flight
        i_req_valid = 4'b1111;
        repeat (2) tick(1'b0, nullrow);
        i_cfg_valid        = 1'b1;
        i_cfg_ifm_datatype = MAC_DATATYPE_FP16;
        i_cfg_wfm_datatype = MAC_DATATYPE_FP16;
        saw = 1'b0;
        for (int n = 0; n < 10 && !saw; n++) begin
            tick(1'b0, nullrow);
            chk("drain_gnt", s_gnt, 4'b0000);
            saw = s_cfg_rdy;
        end
        chk("cfg_ready_seen", saw, 1'b1);
        i_cfg_valid = 1'b0;
        tick(1'b0, nullrow);
        chk("cfg_ifm_fp16", o_cvt_ifm_datatype, MAC_DATATYPE_FP16);
        repeat (4) tick(1'b0, nullrow);
        i_req_valid = 4'b0000;
        repeat (4) tick(1'b0, nullrow);

        // Random traffic with random reconfiguration and a mid-stream reset
        cfg_pending = 1'b0;
        for (int c = 0; c < 400; c++) begin
            i_req_valid = 4'($urandom_range(0, 15));
            i_ready     = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < N; l++) begin
                i_req_exp[l]     = 6'($urandom_range(0, 7));
                i_req_intdata[l] = {2'($urandom_range(0, 3)), 32'($urandom())};
            end
            if (!cfg_pending && $urandom_range(0, 19) == 0) begin
                cfg_pending        = 1'b1;
                i_cfg_valid        = 1'b1;
                i_cfg_ifm_datatype = ($urandom_range(0, 1) != 0) ? MAC_DATATYPE_FP16 : MAC_DATATYPE_I9;
                i_cfg_wfm_datatype = i_cfg_ifm_datatype;
            end
            if (c == 200) begin
                i_cfg_valid = 1'b0;
                cfg_pending = 1'b0;
                i_req_valid = 4'b1111;
                i_ready     = 1'b0;
                repeat (2) tick(1'b0, nullrow);
                #2;
                i_rst = 1'b1;
                #1;
                chk("midrst_valid", o_valid, 1'b0);
                chk("midrst_req_ready", o_req_ready, 4'b0000);
                chk("midrst_busy", o_busy, 1'b0);
`ifdef MAC_CVT_SCHED_PERF_EN
                chk("midrst_perf_conv", o_perf_conv, 32'd0);
                chk("midrst_perf_stall", o_perf_stall, 32'd0);
`endif
                model_reset();
                @(posedge i_clk);
                #1;
                i_rst   = 1'b0;
                i_ready = 1'b1;
                tick(1'b0, nullrow);
                chk("midrst_ptr_lane0", s_gnt, 4'b0001);
            end else begin
                tick(1'b0, nullrow);
                if (cfg_pending && s_cfg_rdy) begin
                    cfg_pending = 1'b0;
                    i_cfg_valid = 1'b0;
                end
            end
        end

        i_cfg_valid = 1'b0;
        i_req_valid = 4'b0000;
        i_ready     = 1'b1;
        repeat (6) tick(1'b0, nullrow);
        chk("final_idle", o_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
